// File: rtl/hdmi_i2c_target.sv
// I2C target exposing an 8-entry byte register file, with a local
// register-mapped access port.
// The I2C side supports a pointer write, auto-incrementing writes and
// reads, and repeated START.
module hdmi_i2c_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h39,
    parameter int unsigned NREG     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busy
);

    localparam int unsigned PTR_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK
    } state_t;

    // Synchronizer and history flops; reset to 1 so an idle bus is assumed.
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    logic scl_rise, scl_fall, start_det, stop_det;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0]   shift, shift_nxt;
    logic [PTR_W-1:0]    ptr, ptr_nxt;
    logic                sda_oe_nxt;
    logic                rw, rw_nxt;
    logic                first_wr, first_wr_nxt;
    logic                rd_pend, rd_pend_nxt;
    logic                busy_nxt;

    logic [BYTE_W-1:0]   regs [NREG];
    logic [BYTE_W-1:0]   byte_in_c;
    logic [BYTE_W-1:0]   rd_cur_c;
    logic [BYTE_W-1:0]   rd_next_c;
    logic [PTR_W-1:0]    ptr_inc_c;
    logic                i2c_we_c;
    logic                local_we_c;
    logic                local_rd_c;
    logic                unused_wdata_hi;

    assign unused_wdata_hi = ^writedata[31:BYTE_W];

    // Bring SCL/SDA into the clk domain and keep one cycle of history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & ~sda_s2 & sda_d;
    assign stop_det  = scl_s2 & scl_d & sda_s2 & ~sda_d;

    assign byte_in_c  = {shift[BYTE_W-2:0], sda_s2};
    assign ptr_inc_c  = ptr + 3'd1;
    assign rd_cur_c   = regs[ptr];
    assign rd_next_c  = regs[ptr_inc_c];
    assign local_we_c = chipselect & ~write_n;
    assign local_rd_c = chipselect & write_n;

    // State and protocol datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            rw       <= 1'b0;
            first_wr <= 1'b0;
            rd_pend  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            ptr      <= ptr_nxt;
            sda_oe   <= sda_oe_nxt;
            rw       <= rw_nxt;
            first_wr <= first_wr_nxt;
            rd_pend  <= rd_pend_nxt;
            busy     <= busy_nxt;
        end
    end

    // Bus protocol: START/STOP override everything, bits move on SCL edges.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        ptr_nxt      = ptr;
        sda_oe_nxt   = sda_oe;
        rw_nxt       = rw;
        first_wr_nxt = first_wr;
        rd_pend_nxt  = rd_pend;
        busy_nxt     = busy;
        i2c_we_c     = 1'b0;

        if (stop_det) begin
            state_nxt   = IDLE;
            sda_oe_nxt  = 1'b0;
            rd_pend_nxt = 1'b0;
            busy_nxt    = 1'b0;
        end else if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            rd_pend_nxt = 1'b0;
            busy_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in_c;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in_c[7:1] == DEV_ADDR) begin
                                state_nxt    = ADDR_ACK;
                                rw_nxt       = byte_in_c[0];
                                first_wr_nxt = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end

                // sda_oe doubles as the ACK phase marker: the first fall starts
                // the ACK, the second fall ends it.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else begin
                            bit_cnt_nxt = '0;
                            if ((state == ADDR_ACK) && rw) begin
                                shift_nxt   = rd_cur_c;
                                sda_oe_nxt  = ~rd_cur_c[7];
                                rd_pend_nxt = 1'b0;
                                state_nxt   = RD_BYTE;
                            end else begin
                                sda_oe_nxt = 1'b0;
                                state_nxt  = WR_BYTE;
                            end
                        end
                    end
                end

                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in_c;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = WR_ACK;
                            if (first_wr) begin
                                ptr_nxt      = byte_in_c[PTR_W-1:0];
                                first_wr_nxt = 1'b0;
                            end else begin
                                i2c_we_c = 1'b1;
                                ptr_nxt  = ptr_inc_c;
                            end
                        end
                    end
                end

                // rd_pend: shift was reloaded after a master ACK and its MSB
                // still has to be put on the bus.
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (rd_pend) begin
                            sda_oe_nxt  = ~shift[7];
                            rd_pend_nxt = 1'b0;
                        end else if (bit_cnt == 3'd7) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = RD_ACK;
                        end else begin
                            shift_nxt   = {shift[BYTE_W-2:0], 1'b0};
                            sda_oe_nxt  = ~shift[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2) begin
                            ptr_nxt     = ptr_inc_c;
                            shift_nxt   = rd_next_c;
                            rd_pend_nxt = 1'b1;
                            bit_cnt_nxt = '0;
                            state_nxt   = RD_BYTE;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end

                default: begin
                    state_nxt  = IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Register file; the local write is issued last so it wins a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[PTR_W'(i)] <= '0;
            end
        end else begin
            if (i2c_we_c) begin
                regs[ptr] <= byte_in_c;
            end
            if (local_we_c) begin
                regs[address] <= writedata[BYTE_W-1:0];
            end
        end
    end

    // Local read data, captured on a read strobe and held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (local_rd_c) begin
            readdata <= {24'h0, regs[address]};
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// Bench for hdmi_i2c_target: a bit-level I2C master plus a byte-level model
// of the register file and pointer.
module tb_hdmi_i2c_target;

    localparam int unsigned Q   = 5;
    localparam logic [6:0]  DEV = 7'h39;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        scl_m;
    logic        m_low;
    logic        sda_bus;
    logic        sda_oe;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic       exp_oe = 1'b0;
    logic [7:0] mreg [8];
    logic [2:0] mptr;
    logic [7:0] tx [8];
    logic [7:0] rx [8];

    assign sda_bus = ~(sda_oe | m_low);

    always #5 clk = ~clk;

    hdmi_i2c_target #(.DEV_ADDR(DEV), .NREG(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .busy       (busy)
    );

    // While SCL is high the target's drive must match what the model expects.
    always @(negedge clk) begin
        if (reset_n && scl_m) begin
            n_checks++;
            if (sda_oe !== exp_oe) begin
                n_errors++;
                $display("FAIL sda_oe_scl_high t=%0t got %b expected %b", $time, sda_oe, exp_oe);
            end
        end
    end

    initial begin
        #3000000;
        n_errors++;
        $display("FAIL timeout");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] e);
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", nm, got, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mptr = 3'd0;
    endtask

    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        exp_oe = 1'b0;
        m_low  = 1'b0;
        qwait();
        scl_m = 1'b1;
        qwait();
        m_low = 1'b1;
        qwait();
        scl_m = 1'b0;
        qwait();
    endtask

    task automatic i2c_stop();
        exp_oe = 1'b0;
        m_low  = 1'b1;
        qwait();
        scl_m = 1'b1;
        qwait();
        m_low = 1'b0;
        qwait();
    endtask

    task automatic send_bit(input logic b);
        exp_oe = 1'b0;
        m_low  = ~b;
        qwait();
        scl_m = 1'b1;
        qwait();
        qwait();
        scl_m = 1'b0;
        qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp, output logic ack_got);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low  = 1'b0;
        exp_oe = ack_exp;
        qwait();
        scl_m = 1'b1;
        qwait();
        ack_got = ~sda_bus;
        qwait();
        scl_m = 1'b0;
        qwait();
    endtask

    task automatic recv_byte(input logic [7:0] e, input logic master_ack, output logic [7:0] got);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            exp_oe = ~e[i];
            qwait();
            scl_m = 1'b1;
            qwait();
            got[i] = sda_bus;
            qwait();
            scl_m = 1'b0;
            qwait();
        end
        exp_oe = 1'b0;
        m_low  = master_ack;
        qwait();
        scl_m = 1'b1;
        qwait();
        qwait();
        scl_m = 1'b0;
        qwait();
        m_low = 1'b0;
    endtask

    task automatic send_addr(input logic [6:0] a, input logic rd);
        logic got;
        logic hit;
        hit = (a == DEV);
        send_byte({a, rd}, hit, got);
        chk("addr_ack", 32'(got), 32'(hit));
    endtask

    // Address (read) phase and n data bytes; master ACKs all but the last.
    task automatic rd_body(input int n);
        logic [7:0] e;
        logic [7:0] g;
        send_addr(DEV, 1'b1);
        for (int i = 0; i < n; i++) begin
            e = mreg[mptr];
            recv_byte(e, (i < n - 1), g);
            rx[i] = g;
            chk("rd_data", 32'(g), 32'(e));
            if (i < n - 1) mptr = mptr + 3'd1;
        end
    endtask

    task automatic xfer_write(input logic [6:0] a, input int n);
        logic hit;
        logic got;
        hit = (a == DEV);
        i2c_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        send_addr(a, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_byte(tx[i], hit, got);
            chk("wr_ack", 32'(got), 32'(hit));
            if (hit) begin
                if (i == 0) begin
                    mptr = tx[0][2:0];
                end else begin
                    mreg[mptr] = tx[i];
                    mptr = mptr + 3'd1;
                end
            end
        end
        i2c_stop();
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic xfer_read(input int n);
        i2c_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        rd_body(n);
        i2c_stop();
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic xfer_ptr_read(input logic [7:0] p, input int n);
        logic got;
        i2c_start();
        send_addr(DEV, 1'b0);
        send_byte(p, 1'b1, got);
        chk("ptr_ack", 32'(got), 32'd1);
        mptr = p[2:0];
        i2c_start();
        rd_body(n);
        i2c_stop();
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic local_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        mreg[a]    = d[7:0];
    endtask

    task automatic local_read(input logic [2:0] a, input logic [31:0] e);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        address    = 3'(a + 3'd1);
        chk("local_read", readdata, e);
        @(negedge clk);
        chk("readdata_hold", readdata, e);
    endtask

    initial begin
        logic       got;
        logic [6:0] ra;
        int         op;
        int         n;

        reset_n    = 1'b0;
        scl_m      = 1'b1;
        m_low      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        local_read(3'd0, 32'd0);
        local_read(3'd5, 32'd0);

        // Local write uses only the low byte.
        local_write(3'd3, 32'h1FF);
        local_read(3'd3, 32'h0000_00FF);

        // Pointer 2 then two data bytes.
        tx[0] = 8'h02; tx[1] = 8'hA5; tx[2] = 8'h5C;
        xfer_write(DEV, 3);
        local_read(3'd2, 32'hA5);
        local_read(3'd3, 32'h5C);
        local_write(3'd4, 32'h3C);
        xfer_read(1);
        chk("ptr4_read", 32'(rx[0]), 32'h3C);

        // Pointer 7, repeated START, read wraps from 7 to 0.
        local_write(3'd7, 32'h77);
        local_write(3'd0, 32'h11);
        xfer_ptr_read(8'h07, 2);
        chk("wrap_rd0", 32'(rx[0]), 32'h77);
        chk("wrap_rd1", 32'(rx[1]), 32'h11);
        xfer_read(1);
        chk("retained_ptr0", 32'(rx[0]), 32'h11);

        // Foreign address: nothing acked, nothing written.
        tx[0] = 8'h01; tx[1] = 8'hEE; tx[2] = 8'hDD;
        xfer_write(7'h50, 3);
        for (int i = 0; i < 8; i++) local_read(3'(i), {24'h0, mreg[i]});

        // STOP after four bits of a data byte.
        i2c_start();
        send_addr(DEV, 1'b0);
        send_byte(8'h05, 1'b1, got);
        chk("ptr5_ack", 32'(got), 32'd1);
        mptr = 3'd5;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        chk("midbyte_stop_busy", 32'(busy), 32'd0);
        chk("midbyte_stop_oe", 32'(sda_oe), 32'd0);
        local_read(3'd5, 32'd0);
        xfer_read(1);

        // Random mix against the model.
        for (int it = 0; it < 24; it++) begin
            op = int'($urandom_range(0, 5));
            n  = int'($urandom_range(1, 4));
            for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
            case (op)
                0: xfer_write(DEV, n);
                1: xfer_read(n);
                2: begin
                    ra = 7'($urandom);
                    if (ra == DEV) ra = ra ^ 7'h01;
                    xfer_write(ra, n);
                end
                3: local_write(3'($urandom), $urandom);
                4: begin
                    ra = 7'($urandom_range(0, 7));
                    local_read(ra[2:0], {24'h0, mreg[ra[2:0]]});
                end
                default: xfer_ptr_read(tx[7], n);
            endcase
        end

        // Asynchronous reset while the target drives a 0 data bit.
        local_write(mptr, 32'h12);
        i2c_start();
        send_addr(DEV, 1'b1);
        chk("rd_drive_before_reset", 32'(sda_oe), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_release", 32'(sda_oe), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_low = 1'b0;
        exp_oe = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) local_read(3'(i), 32'd0);
        i2c_stop();
        tx[0] = 8'h01; tx[1] = 8'hC3;
        xfer_write(DEV, 2);
        tx[0] = 8'h01;
        xfer_write(DEV, 1);
        xfer_read(1);
        chk("post_reset_read", 32'(rx[0]), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
